lc3_memory_responder: RTL

Unified memory responder for the LC-3 multi-cycle processor: it answers the processor's single-port memory interface (`writeEnable`, `address`, `dataToMemory`, `dataFromMemory`) with word-addressed RAM plus memory-mapped console and machine-control registers. It sits opposite the processor core at top level. It provides a testbench preload port and valid/ready byte streams for console input and output.

---
 rtl/lc3_mem_pkg.sv | 18 +
 rtl/lc3_console_regs.sv | 76 +++++++
 rtl/lc3_memory_responder.sv | 78 +++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared constants for the LC-3 memory responder: MMIO register addresses and status bit position.
// Optional MMIO console/MCR support is enabled with the LC3_MEM_MMIO_EN macro.
package lc3_mem_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam int STATUS_BIT = 15;

    function automatic logic is_mmio(input logic [15:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/lc3_console_regs.sv
// Console (keyboard/display) and machine-control registers for the LC-3 memory responder.
// Instantiated by the top only when LC3_MEM_MMIO_EN is defined.
module lc3_console_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        halt
);

    logic        rx_full;
    logic [7:0]  rx_buf;
    logic [15:0] prev_address;
    logic        read_event;
    logic        unused_write_bits;

    // A KBDR read counts once per arrival at the address, not once per cycle held there.
    assign read_event = (address == KBDR_ADDR) && !write_enable && (prev_address != KBDR_ADDR);
    assign rx_ready   = !rx_full;

    assign unused_write_bits = &{1'b0, write_data[14:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            rx_full      <= 1'b0;
            rx_buf       <= 8'h00;
            halt         <= 1'b0;
            prev_address <= 16'h0000;
        end else begin
            prev_address <= address;

            if (write_enable && (address == DDR_ADDR) && !tx_valid) begin
                tx_data  <= write_data[7:0];
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                tx_valid <= 1'b0;
            end

            // Accept and read-clear cannot coincide: rx_ready is low whenever the buffer is full.
            if (rx_valid && !rx_full) begin
                rx_buf  <= rx_data;
                rx_full <= 1'b1;
            end else if (read_event) begin
                rx_full <= 1'b0;
            end

            if (write_enable && (address == MCR_ADDR) && !write_data[STATUS_BIT]) begin
                halt <= 1'b1;
            end
        end
    end

    always_comb begin
        read_data = 16'h0000;
        case (address)
            KBSR_ADDR: read_data[STATUS_BIT] = rx_full;
            KBDR_ADDR: read_data[7:0]        = rx_buf;
            DSR_ADDR:  read_data[STATUS_BIT] = !tx_valid;
            MCR_ADDR:  read_data[STATUS_BIT] = !halt;
            default:   read_data = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_memory_responder.sv
// Unified LC-3 memory responder: word RAM with preload port, plus console/MCR MMIO when
// LC3_MEM_MMIO_EN is defined (otherwise the whole address space is wrapped RAM).
module lc3_memory_responder
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [15:0]           address,
    input  logic [15:0]           dataToMemory,
    output logic [15:0]           dataFromMemory,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [15:0]           load_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  halt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [15:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ram_index;
    logic                  ram_select;

    assign ram_index  = address[ADDR_WIDTH-1:0];
    assign load_ready = !writeEnable;

`ifdef LC3_MEM_MMIO_EN
    logic [15:0] mmio_data;

    assign ram_select     = !is_mmio(address);
    assign dataFromMemory = ram_select ? mem[ram_index] : mmio_data;

    lc3_console_regs u_console_regs (
        .clk          (clk),
        .reset        (reset),
        .write_enable (writeEnable),
        .address      (address),
        .write_data   (dataToMemory),
        .read_data    (mmio_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .halt         (halt)
    );
`else
    logic unused_console;

    assign ram_select     = 1'b1;
    assign dataFromMemory = mem[ram_index];
    assign rx_ready       = 1'b0;
    assign tx_valid       = 1'b0;
    assign tx_data        = 8'h00;
    assign halt           = 1'b0;
    assign unused_console = &{1'b0, rx_valid, rx_data, tx_ready, address};
`endif

    // The processor port owns the single write port; a preload only lands when the core is idle.
    always_ff @(posedge clk) begin
        if (writeEnable && ram_select) begin
            mem[ram_index] <= dataToMemory;
        end else if (load_valid && load_ready) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
